// File: rtl/gauss_window_filter_pkg.sv
// Shared types, constants and helpers for the Gaussian window filter.
// The 2-D kernel is the outer product of the binomial taps [1 2 1].
package gauss_window_filter_pkg;

    localparam int unsigned GAUSS_SHIFT = 4;
    localparam int unsigned GAUSS_K     = 3;
    // Headroom for one kernel row: taps sum to 4, the centre row doubles it to 8.
    localparam int unsigned GAUSS_PART_EXTRA = 3;

    typedef enum logic {
        StRun,
        StDrain
    } frame_state_e;

    function automatic int unsigned gauss_tap(input int unsigned i);
        return (i == GAUSS_K / 2) ? 2 : 1;
    endfunction

    function automatic int unsigned gauss_coef(input int unsigned r, input int unsigned c);
        return gauss_tap(r) * gauss_tap(c);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gauss_window_filter_if.sv
// Column stream in from the row buffer and filtered pixel stream out.
// slave is the filter side, master is the producer/consumer side.
interface gauss_window_filter_if
    import gauss_window_filter_pkg::*;
#(
    parameter int unsigned K           = 3,
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned IMG_W       = 8,
    parameter int unsigned OUT_ROWS    = 6
) ();

    localparam int unsigned ROW_W     = cnt_width(OUT_ROWS);
    localparam int unsigned OUT_COL_W = cnt_width(IMG_W - K + 1);

    logic                     col_valid;
    logic [K*PIXEL_WIDTH-1:0] col_in;
    logic [PIXEL_WIDTH-1:0]   out_pixel;
    logic                     out_valid;
    logic [ROW_W-1:0]         out_row;
    logic [OUT_COL_W-1:0]     out_col;
    logic                     done;

    modport master (
        output col_valid,
        output col_in,
        input  out_pixel,
        input  out_valid,
        input  out_row,
        input  out_col,
        input  done
    );

    modport slave (
        input  col_valid,
        input  col_in,
        output out_pixel,
        output out_valid,
        output out_row,
        output out_col,
        output done
    );

endinterface

// File: rtl/gauss_window_filter_mac_pipe.sv
// Two-stage Gaussian weighted sum: per-row partials, then total and shift.
// A valid/coordinate sideband travels alongside the data; bubbles carry valid=0.
module gauss_window_filter_mac_pipe
    import gauss_window_filter_pkg::*;
#(
    parameter int unsigned K           = 3,
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned SHIFT       = GAUSS_SHIFT,
    parameter int unsigned ROW_W       = 3,
    parameter int unsigned COL_W       = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [ROW_W-1:0]       in_row,
    input  logic [COL_W-1:0]       in_col,
    input  logic [PIXEL_WIDTH-1:0] win [K][K],
    output logic                   out_valid,
    output logic [ROW_W-1:0]       out_row,
    output logic [COL_W-1:0]       out_col,
    output logic [PIXEL_WIDTH-1:0] out_pixel
);

    localparam int unsigned PART_W = PIXEL_WIDTH + GAUSS_PART_EXTRA;
    localparam int unsigned SUM_W  = PIXEL_WIDTH + SHIFT;

    logic [PART_W-1:0]      part_d [K];
    logic [PART_W-1:0]      part_q [K];
    logic                   s1_valid_q;
    logic [ROW_W-1:0]       s1_row_q;
    logic [COL_W-1:0]       s1_col_q;
    logic [SUM_W-1:0]       sum_d;
    logic [PIXEL_WIDTH-1:0] pixel_d;

    always_comb begin
        for (int unsigned r = 0; r < K; r++) begin
            part_d[r] = '0;
            for (int unsigned c = 0; c < K; c++) begin
                part_d[r] = part_d[r] + PART_W'(gauss_coef(r, c)) * PART_W'(win[r][c]);
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int unsigned r = 0; r < K; r++) begin
            sum_d = sum_d + SUM_W'(part_q[r]);
        end
        // Coefficients sum to 2^SHIFT, so the shifted result always fits a pixel.
        pixel_d = PIXEL_WIDTH'(sum_d >> SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < K; r++) begin
                part_q[r] <= '0;
            end
            s1_valid_q <= 1'b0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
            out_valid  <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            out_pixel  <= '0;
        end else begin
            for (int unsigned r = 0; r < K; r++) begin
                part_q[r] <= part_d[r];
            end
            s1_valid_q <= in_valid;
            s1_row_q   <= in_row;
            s1_col_q   <= in_col;
            out_valid  <= s1_valid_q;
            out_row    <= s1_row_q;
            out_col    <= s1_col_q;
            out_pixel  <= pixel_d;
        end
    end

endmodule

// File: rtl/gauss_window_filter.sv
// Shifts incoming pixel columns into a KxK window, tracks row/column position,
// and feeds every complete window to the Gaussian MAC pipeline.
module gauss_window_filter
    import gauss_window_filter_pkg::*;
#(
    parameter int unsigned K           = 3,
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned IMG_W       = 8,
    parameter int unsigned OUT_ROWS    = 6,
    parameter int unsigned SHIFT       = GAUSS_SHIFT
) (
    input logic                  clk,
    input logic                  rst_n,
    gauss_window_filter_if.slave bus
);

    localparam int unsigned COL_CNT_W = cnt_width(IMG_W);
    localparam int unsigned ROW_W     = cnt_width(OUT_ROWS);
    localparam int unsigned OUT_COL_W = cnt_width(IMG_W - K + 1);
    localparam int unsigned FILL_W    = cnt_width(K + 1);

    logic [PIXEL_WIDTH-1:0] win_q [K][K];
    logic [COL_CNT_W-1:0]   col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]       row_cnt_q, row_cnt_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    frame_state_e           state_q;
    logic                   win_valid_q;
    logic [ROW_W-1:0]       win_row_q;
    logic [OUT_COL_W-1:0]   win_col_q;
    logic                   done_q, done_d;

    logic accept, row_end, complete, last_win;

    logic                   mac_valid;
    logic [ROW_W-1:0]       mac_row;
    logic [OUT_COL_W-1:0]   mac_col;
    logic [PIXEL_WIDTH-1:0] mac_pixel;

    always_comb begin
        // Between the final window and done, late columns are dropped.
        accept    = bus.col_valid && (state_q == StRun);
        row_end   = col_cnt_q == COL_CNT_W'(IMG_W - 1);
        complete  = accept && (fill_q >= FILL_W'(K - 1));
        last_win  = complete && row_end && (row_cnt_q == ROW_W'(OUT_ROWS - 1));
        col_cnt_d = row_end ? '0 : col_cnt_q + 1'b1;
        if (row_end) begin
            fill_d = '0;
        end else if (fill_q == FILL_W'(K)) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_q + 1'b1;
        end
        if (!row_end) begin
            row_cnt_d = row_cnt_q;
        end else if (row_cnt_q == ROW_W'(OUT_ROWS - 1)) begin
            row_cnt_d = '0;
        end else begin
            row_cnt_d = row_cnt_q + 1'b1;
        end
        done_d = mac_valid && (mac_row == ROW_W'(OUT_ROWS - 1)) &&
                 (mac_col == OUT_COL_W'(IMG_W - K));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            fill_q      <= '0;
            state_q     <= StRun;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            win_valid_q <= complete;
            done_q      <= done_d;
            if (accept) begin
                for (int unsigned r = 0; r < K; r++) begin
                    for (int unsigned c = 0; c + 1 < K; c++) begin
                        win_q[r][c] <= win_q[r][c+1];
                    end
                    win_q[r][K-1] <= bus.col_in[r*PIXEL_WIDTH +: PIXEL_WIDTH];
                end
                col_cnt_q <= col_cnt_d;
                row_cnt_q <= row_cnt_d;
                fill_q    <= fill_d;
                win_row_q <= row_cnt_q;
                // Window's left edge is K-1 columns behind the column just taken.
                win_col_q <= OUT_COL_W'(col_cnt_q - COL_CNT_W'(K - 1));
            end
            unique case (state_q)
                StRun:   if (last_win) state_q <= StDrain;
                StDrain: if (done_d) state_q <= StRun;
                default: state_q <= StRun;
            endcase
        end
    end

    gauss_window_filter_mac_pipe #(
        .K          (K),
        .PIXEL_WIDTH(PIXEL_WIDTH),
        .SHIFT      (SHIFT),
        .ROW_W      (ROW_W),
        .COL_W      (OUT_COL_W)
    ) u_mac_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (win_valid_q),
        .in_row   (win_row_q),
        .in_col   (win_col_q),
        .win      (win_q),
        .out_valid(mac_valid),
        .out_row  (mac_row),
        .out_col  (mac_col),
        .out_pixel(mac_pixel)
    );

    assign bus.out_valid = mac_valid;
    assign bus.out_row   = mac_row;
    assign bus.out_col   = mac_col;
    assign bus.out_pixel = mac_pixel;
    assign bus.done      = done_q;

endmodule
